// File: rtl/pkt_mux_rr.sv
// pkt_mux_rr: N:1 wormhole packet multiplexer. It locks onto one input port
// from HEAD to TAIL, picking the port by round-robin or by an external select.
// The output flit is registered behind a valid/ready handshake.

// Per-port flit classifier: a valid HEAD may compete for the output; any other
// valid flit is a non-HEAD.
module pkt_mux_rr_port (
    input  logic [1:0] ftype,
    input  logic       vld,
    output logic       head,
    output logic       nonhead
);
    assign head    = vld && (ftype == 2'b01);
    assign nonhead = vld && (ftype != 2'b01);
endmodule

module pkt_mux_rr #(
    parameter int NIN   = 4,
    parameter int DATAW = 66,
    parameter int VCHW  = 2,
    parameter int MODE  = 1,
    parameter int SELW  = $clog2(NIN)
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [NIN*DATAW-1:0] idata,
    input  logic [NIN-1:0]       ivalid,
    input  logic [NIN*VCHW-1:0]  ivch,
    output logic [NIN-1:0]       iready,
    input  logic [SELW-1:0]      sel,
    output logic [DATAW-1:0]     odata,
    output logic                 ovalid,
    output logic [VCHW-1:0]      ovch,
    input  logic                 oready,
    output logic [NIN-1:0]       grant,
    output logic                 busy,
    output logic                 err_drop
);
    localparam logic [1:0]      T_TAIL = 2'b11;
    localparam logic [SELW:0]   NIN_W  = (SELW+1)'(NIN);
    localparam logic [SELW-1:0] LAST   = SELW'(NIN-1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state;
    logic [SELW-1:0]  lock_p;
    logic [SELW-1:0]  rr;
    logic [NIN-1:0]   cand;
    logic [NIN-1:0]   nonhead;
    logic             win_vld;
    logic [SELW-1:0]  win;
    logic [SELW:0]    scan;
    logic             slot_free;
    logic             fwd;
    logic             fwd_tail;
    logic [SELW-1:0]  src;
    logic [DATAW-1:0] src_data;
    logic [VCHW-1:0]  src_vch;

    for (genvar k = 0; k < NIN; k++) begin : g_port
        pkt_mux_rr_port u_port (
            .ftype   (idata[k*DATAW+DATAW-1 -: 2]),
            .vld     (ivalid[k]),
            .head    (cand[k]),
            .nonhead (nonhead[k])
        );
    end

    // Output register can take a new flit when empty or draining this cycle.
    assign slot_free = !ovalid || oready;

    // Arbitration: scan downward from the farthest offset so the candidate
    // nearest rr is written last and wins; sel values past the last port pick nothing.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        scan    = '0;
        if (MODE != 0) begin
            for (int i = NIN-1; i >= 0; i--) begin
                scan = {1'b0, rr} + (SELW+1)'(i);
                if (scan >= NIN_W) scan = scan - NIN_W;
                if (cand[scan[SELW-1:0]]) begin
                    win_vld = 1'b1;
                    win     = scan[SELW-1:0];
                end
            end
        end else if (({1'b0, sel} < NIN_W) && cand[sel]) begin
            win_vld = 1'b1;
            win     = sel;
        end
    end

    // Per-port accept: the locked port only while locked; in IDLE the winning HEAD
    // plus every stray non-HEAD flit, which is swallowed here.
    always_comb begin
        iready = '0;
        if (slot_free) begin
            if (state == LOCK) begin
                iready[lock_p] = 1'b1;
            end else begin
                iready = nonhead;
                if (win_vld) iready[win] = 1'b1;
            end
        end
    end

    assign src      = (state == LOCK) ? lock_p : win;
    assign fwd      = slot_free && ((state == LOCK) ? ivalid[lock_p] : win_vld);
    assign src_data = idata[src*DATAW +: DATAW];
    assign src_vch  = ivch[src*VCHW +: VCHW];
    assign fwd_tail = (src_data[DATAW-1 -: 2] == T_TAIL);

    // Output register: load forwarded flits; drop valid once the consumer takes it.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata  <= '0;
            ovch   <= '0;
            ovalid <= 1'b0;
        end else if (fwd) begin
            odata  <= src_data;
            ovch   <= src_vch;
            ovalid <= 1'b1;
        end else if (oready) begin
            ovalid <= 1'b0;
        end
    end

    // Packet lock FSM with registered grant/busy/err_drop and rr pointer update.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            lock_p   <= '0;
            rr       <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            err_drop <= (state == IDLE) && slot_free && (|nonhead);
            case (state)
                IDLE: if (fwd) begin
                    state  <= LOCK;
                    lock_p <= win;
                    grant  <= NIN'(1) << win;
                    busy   <= 1'b1;
                end
                LOCK: if (fwd && fwd_tail) begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    if (MODE != 0) rr <= (lock_p == LAST) ? '0 : lock_p + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
